quant_drain_scheduler: RTL and testbench

Round-robin scheduler that shares one saturating quantizer among several accumulator columns of the MAC array. It grants one column at a time and drains a burst of PACK 24-bit accumulator results from it. Each result is right-shifted, saturated to 8 bits and packed into one 32-bit output word tagged with the source column. It sits between the accumulator bank and the activation/output buffer.

---
 rtl/quant_drain_scheduler.sv | 140 ++++++++++++++
 tb/tb_quant_drain_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_drain_scheduler.sv
// Round-robin drain of accumulator columns through one shared saturating quantizer.
// Each grant collects PACK right-shifted, 8-bit-saturated results into one tagged output word.
module quant_drain_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ACC_W   = 24,
  parameter int PACK    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ACC_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4:0]                 cfg_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*PACK-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       busy
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PACK);
  localparam logic [4:0] MAX_SHIFT = 5'(ACC_W - 1);

  typedef enum logic [1:0] {IDLE, ARB, COLLECT, OUT} state_t;

  state_t              state_reg, state_next;
  logic                rst_ok_reg;
  logic [SW-1:0]       rr_ptr_reg;
  logic [SW-1:0]       grant_reg;
  logic [4:0]          shift_reg;
  logic [CW-1:0]       cnt_reg;
  logic [8*(PACK-1)-1:0] pack_reg;
  logic [8*PACK-1:0]   out_data_reg;
  logic [SW-1:0]       out_src_reg;

  logic [ACC_W-1:0]    col_data [NUM_REQ];
  logic [ACC_W-1:0]    sel_data;
  logic [ACC_W-1:0]    shifted;
  logic [7:0]          sat_byte;
  logic                hs;
  logic                last_byte;
  logic                arb_found;
  logic [SW-1:0]       arb_idx;
  logic [SW-1:0]       cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_col
      assign col_data[gi]  = req_data[gi*ACC_W +: ACC_W];
      assign req_ready[gi] = (state_reg == COLLECT) && (grant_reg == SW'(gi));
    end
  endgenerate

  // Quantizer: saturate on the full shifted value before keeping the low byte.
  assign sel_data  = col_data[grant_reg];
  assign shifted   = sel_data >> shift_reg;
  assign sat_byte  = (|shifted[ACC_W-1:8]) ? 8'hFF : shifted[7:0];
  assign hs        = (state_reg == COLLECT) && req_valid[grant_reg];
  assign last_byte = (cnt_reg == CW'(PACK - 1));

  assign out_valid = (state_reg == OUT);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

  // Rotating priority search starting at rr_ptr; index wraps by truncation.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_reg + SW'(i);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Release is taken through one flop so the FSM sits in IDLE for a cycle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_ok_reg <= 1'b0;
    else      rst_ok_reg <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_valid) state_next = ARB;
      ARB:     state_next = arb_found ? COLLECT : IDLE;
      COLLECT: if (hs && last_byte) state_next = OUT;
      OUT:     if (out_ready) state_next = (|req_valid) ? ARB : IDLE;
      default: state_next = IDLE;
    endcase
    if (!rst_ok_reg) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      pack_reg     <= '0;
      out_data_reg <= '0;
      out_src_reg  <= '0;
    end else begin
      case (state_reg)
        ARB: begin
          if (arb_found) grant_reg <= arb_idx;
          shift_reg <= (cfg_shift > MAX_SHIFT) ? MAX_SHIFT : cfg_shift;
          cnt_reg   <= '0;
        end
        COLLECT: begin
          if (hs) begin
            cnt_reg <= cnt_reg + CW'(1);
            for (int i = 0; i < PACK - 1; i++) begin
              if (cnt_reg == CW'(i)) pack_reg[i*8 +: 8] <= sat_byte;
            end
            if (last_byte) begin
              out_data_reg <= {sat_byte, pack_reg};
              out_src_reg  <= grant_reg;
            end
          end
        end
        OUT: begin
          if (out_ready) rr_ptr_reg <= grant_reg + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quant_drain_scheduler.sv
// Scoreboard bench for quant_drain_scheduler: column source queues feed the DUT,
// expected words are queued with the stimulus and compared as words are accepted.
module tb_quant_drain_scheduler;

  localparam int NR = 4;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [4:0]      cfg_shift = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_data;
  logic [1:0]      out_src;
  logic            busy;

  quant_drain_scheduler #(.NUM_REQ(NR), .ACC_W(AW), .PACK(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] colq [NR][$];
  bit          gap [NR];
  int          hs_cnt [NR];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_checks = 0;
  int          or_hold = 0;
  bit          hold_seen = 0;
  logic [31:0] hold_data;
  logic [1:0]  hold_src;
  int          burst_bytes = 0;
  bit          ov_expect = 0;
  bit          multi_ready = 0;
  bit          rr_timing = 0;
  int          last_acc = -1;
  bit          lat_arm = 0;
  int          lat_t0 = -1;
  bit          watch_busy = 0;
  bit          busy_drop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (colq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock: at the falling edge, consume what the coming rising edge will accept.
  task automatic cycle();
    logic [NR-1:0] hs;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (ov_expect) begin
      check("out_valid_rise", 32'(out_valid), 32'd1);
      ov_expect = 0;
    end
    if (out_valid && or_hold > 0) begin
      out_ready = 1'b0;
      if (!hold_seen) begin
        hold_data = out_data;
        hold_src  = out_src;
        hold_seen = 1;
      end else begin
        check("hold_data", out_data, hold_data);
        check("hold_src", 32'(out_src), 32'(hold_src));
      end
      check("hold_ready", 32'(req_ready), 32'd0);
      or_hold--;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid && out_ready) begin
      $display("[cyc %0d] word src=%0d data=0x%08h", cyc, out_src, out_data);
      if (sb.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_src", 32'(out_src), 32'(e.src));
      end
      if (rr_timing && last_acc >= 0) check("burst_period", 32'(cyc - last_acc), 32'd6);
      last_acc   = cyc;
      hold_seen  = 0;
      watch_busy = 0;
    end
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (colq[i].size() > 0) && !(gap[i] && req_ready[i] && (cyc % 2 == 1));
      req_data[i*AW +: AW] = (colq[i].size() > 0) ? colq[i][0] : 24'd0;
    end
    if (lat_arm && lat_t0 < 0 && req_valid != 0) lat_t0 = cyc;
    if (lat_arm && req_ready != 0) begin
      check("latency", 32'(cyc - lat_t0), 32'd2);
      lat_arm = 0;
    end
    if ($countones(req_ready) > 1) multi_ready = 1;
    if (watch_busy && !busy) busy_drop = 1;
    hs = req_valid & req_ready;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        void'(colq[i].pop_front());
        hs_cnt[i]++;
        burst_bytes++;
      end
    end
    if (burst_bytes == 4) begin
      ov_expect   = 1;
      burst_bytes = 0;
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (n < budget && !(sb.size() == 0 && queues_empty() && !busy));
    if (n >= budget) begin
      check("timeout", 32'd0, 32'd1);
      sb.delete();
      for (int i = 0; i < NR; i++) colq[i].delete();
    end
  endtask

  task automatic wait_hs(input int col, input int target, input int budget);
    int n = 0;
    while (hs_cnt[col] < target && n < budget) begin
      cycle();
      n++;
    end
    if (hs_cnt[col] < target) check("hs_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      gap[i] = 0;
      hs_cnt[i] = 0;
    end
    #1 rst = 1'b0;
    repeat (3) cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    rst = 1'b1;
    repeat (3) cycle();

    // Round robin: every column valid continuously from rr_ptr = 0.
    colq[0] = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd9, 24'd10, 24'd11, 24'd12};
    colq[1] = '{24'h10, 24'h20, 24'h30, 24'h40};
    colq[2] = '{24'd300, 24'd300, 24'd300, 24'd300};
    colq[3] = '{24'd5, 24'd6, 24'd7, 24'd8};
    sb.push_back('{src: 2'd0, data: 32'h04030201});
    sb.push_back('{src: 2'd1, data: 32'h40302010});
    sb.push_back('{src: 2'd2, data: 32'hFFFFFFFF});
    sb.push_back('{src: 2'd3, data: 32'h08070605});
    sb.push_back('{src: 2'd0, data: 32'h0C0B0A09});
    rr_timing = 1;
    last_acc  = -1;
    run_until_done(200);
    rr_timing = 0;
    check("ready_onehot", 32'(multi_ready), 32'd0);

    // Single column, shift 0, with 5 cycles of backpressure in OUT.
    colq[0] = '{24'd100, 24'd256, 24'd1024, 24'd200};
    sb.push_back('{src: 2'd0, data: 32'hC8FFFF64});
    lat_arm = 1;
    lat_t0  = -1;
    or_hold = 5;
    run_until_done(100);
    check("bp_released", 32'(or_hold), 32'd0);
    check("idle_after_bp", 32'(out_valid), 32'd0);

    // Shift 2 with cfg_shift changed mid-burst.
    cfg_shift = 5'd2;
    colq[1] = '{24'd1020, 24'd1024, 24'd400, 24'd3};
    sb.push_back('{src: 2'd1, data: 32'h0064FFFF});
    wait_hs(1, hs_cnt[1] + 1, 50);
    cfg_shift = 5'd0;
    run_until_done(100);

    // Column 2 with gaps; busy must stay high across the whole burst.
    gap[2]  = 1;
    colq[2] = '{24'd255, 24'd0, 24'h22, 24'h10};
    sb.push_back('{src: 2'd2, data: 32'h102200FF});
    for (int n = 0; n < 10 && !busy; n++) cycle();
    watch_busy = 1;
    busy_drop  = 0;
    run_until_done(100);
    gap[2] = 0;
    check("busy_gap", 32'(busy_drop), 32'd0);

    // rr_ptr is now 3: column 3 goes before column 0. Shift 31 acts as 23.
    cfg_shift = 5'd31;
    colq[3] = '{24'hFFFFFF, 24'h800000, 24'h7FFFFF, 24'hFFFFFF};
    colq[0] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    sb.push_back('{src: 2'd3, data: 32'h01000101});
    sb.push_back('{src: 2'd0, data: 32'h01010101});
    run_until_done(100);
    cfg_shift = 5'd0;

    // Reset after two bytes of a column 0 burst; the partial pack must vanish.
    colq[0] = '{24'h50, 24'h51, 24'h52, 24'h53};
    wait_hs(0, hs_cnt[0] + 2, 50);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    colq[0].delete();
    burst_bytes = 0;
    ov_expect   = 0;
    repeat (3) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    colq[0] = '{24'd1, 24'd2, 24'd3, 24'd4};
    sb.push_back('{src: 2'd0, data: 32'h04030201});
    run_until_done(100);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
